dpram_port_arbiter: RTL

Round-robin arbiter that shares one port of the team's dual-port RAM (WIDTH × DEPTH, registered read) among NREQ requesters. Each requester presents a read or write command with a req/gnt handshake. The arbiter registers the winning command onto the RAM port and routes returned read data back to the issuing requester with a valid strobe. One instance sits in front of each RAM port that more than one client must use.

---
 rtl/dpram_arb_pkg.sv | 29 ++
 rtl/dpram_port_arbiter_if.sv | 34 +++
 rtl/dpram_port_arbiter_rr_arbiter.sv | 33 +++
 rtl/dpram_port_arbiter.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/dpram_arb_pkg.sv
// Shared defaults, command/lock types and helpers for dpram_port_arbiter.
// The lock feature is selected by DPRAM_ARB_LOCK_EN in the top level.
package dpram_arb_pkg;

   localparam int DEF_WIDTH   = 8;
   localparam int DEF_ADDRESS = 6;
   localparam int DEF_DEPTH   = 2 ** DEF_ADDRESS;
   localparam int DEF_NREQ    = 4;
   localparam int DEF_IDXW    = $clog2(DEF_NREQ);

   typedef struct packed {
      logic                   we;
      logic [DEF_ADDRESS-1:0] addr;
      logic [DEF_WIDTH-1:0]   din;
   } cmd_t;

   typedef enum logic {
      LOCK_IDLE,
      LOCK_HELD
   } lock_state_t;

   // Index reached by stepping 'step' positions past 'base' on a ring of n.
   function automatic int unsigned rr_next(input int unsigned base,
                                           input int unsigned step,
                                           input int unsigned n);
      return (base + step) % n;
   endfunction

endpackage

// File: rtl/dpram_port_arbiter_if.sv
// Requester and RAM-port signal bundle for dpram_port_arbiter.
// master = requesters plus RAM side, slave = the arbiter.
interface dpram_port_arbiter_if
   import dpram_arb_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int ADDRESS = DEF_ADDRESS,
   parameter int NREQ    = DEF_NREQ
) ();

   logic [NREQ-1:0]         req;
   logic [NREQ-1:0]         req_we;
   logic [NREQ*ADDRESS-1:0] req_addr;
   logic [NREQ*WIDTH-1:0]   req_din;
   logic [NREQ-1:0]         req_lock;
   logic [NREQ-1:0]         gnt;
   logic [NREQ-1:0]         rd_valid;
   logic [WIDTH-1:0]        rd_data;
   logic [ADDRESS-1:0]      ram_addr;
   logic [WIDTH-1:0]        ram_din;
   logic                    ram_we;
   logic [WIDTH-1:0]        ram_dout;

   modport master (
      output req, req_we, req_addr, req_din, req_lock, ram_dout,
      input  gnt, rd_valid, rd_data, ram_addr, ram_din, ram_we
   );

   modport slave (
      input  req, req_we, req_addr, req_din, req_lock, ram_dout,
      output gnt, rd_valid, rd_data, ram_addr, ram_din, ram_we
   );

endinterface

// File: rtl/dpram_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: search starts one past ptr and wraps,
// producing a one-hot grant and the winner index.
module rr_arbiter
   import dpram_arb_pkg::*;
#(
   parameter int NREQ = DEF_NREQ,
   parameter int IDXW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDXW-1:0] ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDXW-1:0] win,
   output logic            any
);

   logic [IDXW-1:0] cand;

   always_comb begin
      gnt  = '0;
      win  = '0;
      any  = 1'b0;
      cand = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand = IDXW'(rr_next(32'(ptr), k, NREQ));
         if (!any && req[cand]) begin
            any       = 1'b1;
            win       = cand;
            gnt[cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/dpram_port_arbiter.sv
// Shares one registered-read RAM port among NREQ requesters, round-robin.
// Define DPRAM_ARB_LOCK_EN to let a winner hold the port via req_lock.
module dpram_port_arbiter
   import dpram_arb_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int ADDRESS = DEF_ADDRESS,
   parameter int NREQ    = DEF_NREQ
) (
   input logic                 clk,
   input logic                 rst_n,
   dpram_port_arbiter_if.slave bus
);

   localparam int IDXW = $clog2(NREQ);

   logic [IDXW-1:0]    ptr_q;
   logic [NREQ-1:0]    arb_gnt;
   logic [IDXW-1:0]    arb_win;
   logic               arb_any;
   logic [NREQ-1:0]    gnt_sel;
   logic [IDXW-1:0]    win_sel;
   logic               grant;

   logic               sel_we;
   logic [ADDRESS-1:0] sel_addr;
   logic [WIDTH-1:0]   sel_din;

   logic               ram_we_q;
   logic [ADDRESS-1:0] ram_addr_q;
   logic [WIDTH-1:0]   ram_din_q;

   logic               s1_valid;
   logic               s2_valid;
   logic [IDXW-1:0]    s1_idx;
   logic [IDXW-1:0]    s2_idx;
   logic [NREQ-1:0]    rd_valid;

   rr_arbiter #(
      .NREQ (NREQ),
      .IDXW (IDXW)
   ) u_rr (
      .req  (bus.req),
      .ptr  (ptr_q),
      .gnt  (arb_gnt),
      .win  (arb_win),
      .any  (arb_any)
   );

`ifdef DPRAM_ARB_LOCK_EN
   lock_state_t lock_q;
   lock_state_t lock_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lock_q <= LOCK_IDLE;
      else        lock_q <= lock_d;
   end

   // ptr_q always names the holder while locked; once the holder lets go,
   // that same cycle falls back to normal arbitration starting after it.
   always_comb begin
      gnt_sel = arb_gnt;
      win_sel = arb_win;
      grant   = arb_any;
      lock_d  = LOCK_IDLE;
      unique case (lock_q)
         LOCK_HELD: begin
            if (bus.req[ptr_q] && bus.req_lock[ptr_q]) begin
               gnt_sel        = '0;
               gnt_sel[ptr_q] = 1'b1;
               win_sel        = ptr_q;
               grant          = 1'b1;
            end
         end
         default: ;
      endcase
      if (grant && bus.req_lock[win_sel]) lock_d = LOCK_HELD;
   end
`else
   logic unused_lock;

   assign unused_lock = ^bus.req_lock;
   assign gnt_sel     = arb_gnt;
   assign win_sel     = arb_win;
   assign grant       = arb_any;
`endif

   always_comb begin
      sel_we   = 1'b0;
      sel_addr = '0;
      sel_din  = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (IDXW'(i) == win_sel) begin
            sel_we   = bus.req_we[i];
            sel_addr = bus.req_addr[i*ADDRESS +: ADDRESS];
            sel_din  = bus.req_din[i*WIDTH +: WIDTH];
         end
      end
   end

   // Address and data hold across idle cycles; only the write enable pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= IDXW'(NREQ - 1);
         ram_we_q   <= 1'b0;
         ram_addr_q <= '0;
         ram_din_q  <= '0;
      end else begin
         ram_we_q <= grant & sel_we;
         if (grant) begin
            ptr_q      <= win_sel;
            ram_addr_q <= sel_addr;
            ram_din_q  <= sel_din;
         end
      end
   end

   // Stage 1 lines up with the RAM command, stage 2 with the RAM's registered dout.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_idx   <= '0;
         s2_valid <= 1'b0;
         s2_idx   <= '0;
      end else begin
         s1_valid <= grant & ~sel_we;
         s1_idx   <= win_sel;
         s2_valid <= s1_valid;
         s2_idx   <= s1_idx;
      end
   end

   always_comb begin
      rd_valid = '0;
      if (s2_valid) rd_valid[s2_idx] = 1'b1;
   end

   assign bus.gnt      = gnt_sel;
   assign bus.rd_valid = rd_valid;
   assign bus.rd_data  = bus.ram_dout;
   assign bus.ram_we   = ram_we_q;
   assign bus.ram_addr = ram_addr_q;
   assign bus.ram_din  = ram_din_q;

endmodule
